tristate_bus_ctrl: RTL and testbench
====================================

// Module: tristate_bus_ctrl
// PURPOSE
//   Half-duplex controller for a shared tristate bus. Sits directly upstream of the bufif0/bufif1
//   driver and receiver stage.
//   - Generates the driver enable (bus_oe) and the driven value (bus_out).
//   - Samples the returning bus value (bus_in).
//   - Enforces hold and turnaround windows so two drivers never contend.
//   - Offers a valid/ready write port and a req/gnt read port to core logic.
// PARAMETERS
//   WIDTH        8  bus and data width in bits
//   HOLD_CYCLES  2  cycles bus_oe stays high per write word (>=1)
//   TURN_CYCLES  2  cycles bus_oe is forced low after a write burst before any new access (>=1)
// PORTS
//   clock      in   1      single clock; all logic on rising edge
//   reset_n    in   1      synchronous, active-low reset
//   tx_valid   in   1      write word available
//   tx_data    in   WIDTH  write word
//   tx_ready   out  1      write word accepted when tx_valid & tx_ready
//   rx_req     in   1      read request
//   rx_gnt     out  1      read accepted when rx_req & rx_gnt
//   rx_valid   out  1      one-cycle pulse; rx_data valid
//   rx_data    out  WIDTH  sampled bus value
//   bus_out    out  WIDTH  value to the tristate driver data input
//   bus_oe     out  1      tristate driver enable (1 = drive)
//   bus_in     in   WIDTH  value read back from the bus pad
//   busy       out  1      state != IDLE
//   collision  out  1      sticky contention flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset values (on the clock edge with reset_n=0)
//   - All outputs are 0; state is IDLE.
//   - Reset overrides everything, including mid-DRIVE: bus_oe drops on that edge, turnaround is skipped.
//   States: IDLE, DRIVE, TURN, SAMPLE. The counter is $clog2(max(HOLD,TURN)+1) bits.
//   IDLE
//   - tx_ready=1.
//   - rx_gnt = ~tx_valid. Write has priority when tx_valid and rx_req are both high.
//   - Write accepted -> latch tx_data, go to DRIVE, cnt=0.
//   - Else read accepted -> go to SAMPLE.
//   DRIVE
//   - bus_oe=1, bus_out = latched word; cnt increments each cycle.
//   - tx_ready=1 only in the last cycle (cnt==HOLD_CYCLES-1).
//   - If a word is accepted in that cycle: latch it, stay in DRIVE, cnt=0. bus_oe has no gap.
//   - Else at the last cycle go to TURN, cnt=0.
//   TURN
//   - bus_oe=0; tx_ready=0; rx_gnt=0.
//   - After TURN_CYCLES cycles go to IDLE.
//   SAMPLE
//   - Lasts 1 cycle, bus_oe=0.
//   - bus_in is registered into rx_data at the end of this cycle.
//   - rx_valid=1 for the following cycle (state is IDLE again).
//   - A new request may be granted in that same cycle.
//   Latency
//   - Write accepted at cycle N: bus_oe=1 in cycles N+1..N+HOLD_CYCLES.
//   - Read granted at cycle N: rx_valid at N+2.
//   Invariant: bus_oe never rises within TURN_CYCLES of falling, except after reset.
//   bus_out holds its last value while bus_oe=0.
// CONFIGURATION
//   BUS_CTRL_COLLISION_EN defined
//   - Compare bus_in against bus_out in every DRIVE cycle except the first cycle of each word
//     (settle cycle).
//   - Any mismatch sets collision=1 on the next edge.
//   - collision is sticky; only reset clears it. Data flow is unaffected.
//   BUS_CTRL_COLLISION_EN undefined
//   - collision is tied to 0 and no comparator is built.
// TESTING  (WIDTH=8, HOLD_CYCLES=2, TURN_CYCLES=2)
//   1. reset_n=0 for 2 cycles, then 1 -> bus_oe=0, busy=0, rx_valid=0, collision=0;
//      tx_ready=1 and rx_gnt=1 in the first cycle.
//   2. Write 0xA5 accepted at c0 -> bus_oe=1 with bus_out=0xA5 in c1-c2; bus_oe=0 and busy=1 in c3-c4;
//      tx_ready=1 in c5.
//   3. Stream 0x11, 0x22 with tx_valid held -> bus_oe high for 4 consecutive cycles (0x11,0x11,0x22,0x22),
//      then 2 TURN cycles.
//   4. rx_req at c0 with bus_in=0x3C -> rx_gnt=1 at c0; rx_valid=1 with rx_data=0x3C at c2 only.
//   5. tx_valid and rx_req both high in IDLE -> write wins, rx_gnt=0.
//      The read is granted only after the 2 TURN cycles.
//   6. reset_n=0 in the first DRIVE cycle -> bus_oe=0 on the next edge.
//      With the macro defined: drive 0xFF while bus_in=0x00 -> collision=1 and stays 1 until reset.
//      With the macro undefined: collision=0.

Source files
------------

// File: rtl/tristate_bus_ctrl.sv
// tristate_bus_ctrl: half-duplex controller for a shared tristate bus with hold and turnaround windows.
// Define BUS_CTRL_COLLISION_EN to build the sticky contention detector (collision tied low otherwise).
module tristate_bus_ctrl #(
   parameter int WIDTH       = 8,
   parameter int HOLD_CYCLES = 2,
   parameter int TURN_CYCLES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tx_valid,
   input  logic [WIDTH-1:0] tx_data,
   output logic             tx_ready,
   input  logic             rx_req,
   output logic             rx_gnt,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   input  logic [WIDTH-1:0] bus_in,
   output logic             busy,
   output logic             collision
);

   localparam int CNT_MAX = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      TURN   = 2'd2,
      SAMPLE = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] rx_data_r;
   logic             rx_valid_r;
   logic             bus_oe_r;
   logic             busy_r;
   logic             load_s;
   logic             tx_ready_s;
   logic             rx_gnt_s;

   // Next-state, counter and handshake decode
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      tx_ready_s = 1'b0;
      rx_gnt_s   = 1'b0;
      load_s     = 1'b0;
      case (state_r)
         IDLE: begin
            tx_ready_s = 1'b1;
            rx_gnt_s   = ~tx_valid;
            if (tx_valid) begin
               load_s  = 1'b1;
               state_s = DRIVE;
               cnt_s   = '0;
            end else if (rx_req) begin
               state_s = SAMPLE;
            end else begin
               state_s = IDLE;
            end
         end
         DRIVE: begin
            // Back-to-back words are only accepted in the last hold cycle so bus_oe never gaps.
            if (cnt_r == HOLD_LAST) begin
               tx_ready_s = 1'b1;
               cnt_s      = '0;
               if (tx_valid) begin
                  load_s  = 1'b1;
                  state_s = DRIVE;
               end else begin
                  state_s = TURN;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         TURN: begin
            if (cnt_r == TURN_LAST) begin
               state_s = IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         SAMPLE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         data_r     <= '0;
         rx_data_r  <= '0;
         rx_valid_r <= 1'b0;
         bus_oe_r   <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         rx_valid_r <= (state_r == SAMPLE);
         bus_oe_r   <= (state_s == DRIVE);
         busy_r     <= (state_s != IDLE);
         if (load_s) begin
            data_r <= tx_data;
         end else begin
            data_r <= data_r;
         end
         if (state_r == SAMPLE) begin
            rx_data_r <= bus_in;
         end else begin
            rx_data_r <= rx_data_r;
         end
      end
   end

`ifdef BUS_CTRL_COLLISION_EN
   logic collision_r;

   // Sticky contention flag; the first cycle of each word is a settle cycle and is not compared
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         collision_r <= 1'b0;
      end else if ((state_r == DRIVE) && (cnt_r != '0) && (bus_in != data_r)) begin
         collision_r <= 1'b1;
      end else begin
         collision_r <= collision_r;
      end
   end

   assign collision = collision_r;
`else
   assign collision = 1'b0;
`endif

   assign tx_ready = tx_ready_s & reset_n;
   assign rx_gnt   = rx_gnt_s & reset_n;
   assign rx_valid = rx_valid_r;
   assign rx_data  = rx_data_r;
   assign bus_out  = data_r;
   assign bus_oe   = bus_oe_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Self-checking bench for tristate_bus_ctrl: directed vector table, hand sequences for reset and
// contention, and randomized traffic against a cycle-timeline reference model.
module tb_tristate_bus_ctrl;

   localparam int HOLD = 2;
   localparam int TURN = 2;
`ifdef BUS_CTRL_COLLISION_EN
   localparam logic COLL_EN = 1'b1;
`else
   localparam logic COLL_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       rx_req = 1'b0;
   logic       rx_gnt;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic [7:0] bus_in = 8'h00;
   logic       busy;
   logic       collision;

   int errors = 0;
   int checks = 0;

   tristate_bus_ctrl #(.WIDTH(8), .HOLD_CYCLES(HOLD), .TURN_CYCLES(TURN)) dut (
      .clock(clock), .reset_n(reset_n), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_req(rx_req), .rx_gnt(rx_gnt), .rx_valid(rx_valid),
      .rx_data(rx_data), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
      .busy(busy), .collision(collision)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst;
      logic       txv;
      logic [7:0] txd;
      logic       rxr;
      logic [7:0] bin;
      logic       e_txr;
      logic       e_gnt;
      logic       e_oe;
      logic [7:0] e_out;
      logic       e_busy;
      logic       e_rxv;
      logic [7:0] e_rxd;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rst, txv, input logic [7:0] txd, input logic rxr,
                               input logic [7:0] bin, input logic e_txr, e_gnt, e_oe,
                               input logic [7:0] e_out, input logic e_busy, e_rxv,
                               input logic [7:0] e_rxd);
      vec_t v;
      v.rst = rst; v.txv = txv; v.txd = txd; v.rxr = rxr; v.bin = bin;
      v.e_txr = e_txr; v.e_gnt = e_gnt; v.e_oe = e_oe; v.e_out = e_out;
      v.e_busy = e_busy; v.e_rxv = e_rxv; v.e_rxd = e_rxd;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic step(input logic r, tv, input logic [7:0] td, input logic rr,
                       input logic [7:0] bi);
      @(negedge clock);
      reset_n = r; tx_valid = tv; tx_data = td; rx_req = rr; bus_in = bi;
      #1;
   endtask

   // Reference model: absolute cycle timeline of the current word and the pending read.
   int         t, word_end, idle_from, rd_time;
   logic [7:0] m_word, m_rxd;
   logic       m_coll;

   initial begin
      // rst txv txd rxr bin | txr gnt oe out busy rxv rxd
      vq.push_back(mk(0,0,8'h00,0,8'h00, 0,0,0,8'h00,0,0,8'h00)); // reset state
      vq.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'h00,0,0,8'h00)); // first cycle out of reset
      vq.push_back(mk(1,1,8'hA5,0,8'h00, 1,0,0,8'h00,0,0,8'h00)); // write A5 accepted c0
      vq.push_back(mk(1,0,8'h00,0,8'h00, 0,0,1,8'hA5,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 1,0,1,8'hA5,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'hA5,1,0,8'h00)); // turnaround
      vq.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'hA5,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'hA5,0,0,8'h00)); // ready again c5
      vq.push_back(mk(1,1,8'h11,0,8'h00, 1,0,0,8'hA5,0,0,8'h00)); // stream 11,22
      vq.push_back(mk(1,1,8'h22,0,8'h00, 0,0,1,8'h11,1,0,8'h00));
      vq.push_back(mk(1,1,8'h22,0,8'h00, 1,0,1,8'h11,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 0,0,1,8'h22,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 1,0,1,8'h22,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h22,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h22,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,1,8'h3C, 1,1,0,8'h22,0,0,8'h00)); // read granted c0
      vq.push_back(mk(1,0,8'h00,0,8'h3C, 0,0,0,8'h22,1,0,8'h00));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'h22,0,1,8'h3C)); // rx_valid c2
      vq.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'h22,0,0,8'h3C));
      vq.push_back(mk(1,1,8'h5A,1,8'h00, 1,0,0,8'h22,0,0,8'h3C)); // write beats read
      vq.push_back(mk(1,0,8'h00,1,8'h00, 0,0,1,8'h5A,1,0,8'h3C));
      vq.push_back(mk(1,0,8'h00,1,8'h00, 1,0,1,8'h5A,1,0,8'h3C));
      vq.push_back(mk(1,0,8'h00,1,8'h00, 0,0,0,8'h5A,1,0,8'h3C));
      vq.push_back(mk(1,0,8'h00,1,8'h00, 0,0,0,8'h5A,1,0,8'h3C));
      vq.push_back(mk(1,0,8'h00,1,8'h77, 1,1,0,8'h5A,0,0,8'h3C)); // read after turnaround
      vq.push_back(mk(1,0,8'h00,0,8'h77, 0,0,0,8'h5A,1,0,8'h3C));
      vq.push_back(mk(1,0,8'h00,1,8'h00, 1,1,0,8'h5A,0,1,8'h77)); // regrant in rx_valid cycle
      vq.push_back(mk(1,0,8'h00,0,8'h99, 0,0,0,8'h5A,1,0,8'h77));
      vq.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'h5A,0,1,8'h99));

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].txv, vq[i].txd, vq[i].rxr, vq[i].bin);
         check("tbl_tx_ready", i, 32'(tx_ready), 32'(vq[i].e_txr));
         check("tbl_rx_gnt",   i, 32'(rx_gnt),   32'(vq[i].e_gnt));
         check("tbl_bus_oe",   i, 32'(bus_oe),   32'(vq[i].e_oe));
         check("tbl_bus_out",  i, 32'(bus_out),  32'(vq[i].e_out));
         check("tbl_busy",     i, 32'(busy),     32'(vq[i].e_busy));
         check("tbl_rx_valid", i, 32'(rx_valid), 32'(vq[i].e_rxv));
         check("tbl_rx_data",  i, 32'(rx_data),  32'(vq[i].e_rxd));
      end

      // Reset in the first DRIVE cycle: bus released at once, no turnaround afterwards.
      step(1, 1, 8'hFF, 0, 8'h00);
      check("pre_drive_ready", 0, 32'(tx_ready), 32'(1'b1));
      step(0, 0, 8'h00, 0, 8'h00);
      check("mid_drive_oe", 0, 32'(bus_oe), 32'(1'b1));
      step(1, 0, 8'h00, 0, 8'h00);
      check("post_rst_oe",    0, 32'(bus_oe),    32'(1'b0));
      check("post_rst_busy",  0, 32'(busy),      32'(1'b0));
      check("post_rst_ready", 0, 32'(tx_ready),  32'(1'b1));
      check("post_rst_coll",  0, 32'(collision), 32'(1'b0));

      // Drive FF against a bus reading 00: settle cycle ignored, then sticky flag.
      step(1, 1, 8'hFF, 0, 8'h00);
      step(1, 0, 8'h00, 0, 8'h00);
      check("coll_before", 0, 32'(collision), 32'(1'b0));
      step(1, 0, 8'h00, 0, 8'h00);
      check("coll_settle", 0, 32'(collision), 32'(1'b0));
      check("coll_drive",  0, 32'(bus_out),   32'(8'hFF));
      step(1, 0, 8'h00, 0, 8'h00);
      check("coll_set", 0, 32'(collision), 32'(COLL_EN));
      for (int k = 0; k < 4; k++) step(1, 0, 8'h00, 0, 8'h00);
      check("coll_sticky", 0, 32'(collision), 32'(COLL_EN));
      step(0, 0, 8'h00, 0, 8'h00);
      step(1, 0, 8'h00, 0, 8'h00);
      check("coll_cleared", 0, 32'(collision), 32'(1'b0));

      // Randomized traffic against the timeline model.
      step(0, 0, 8'h00, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00);
      t = 0; word_end = -1000; idle_from = 0; rd_time = -1000;
      m_word = 8'h00; m_rxd = 8'h00; m_coll = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         logic       r, tv, rr, idle, e_txr, e_gnt;
         logic [7:0] td, bi;
         r  = ($urandom_range(0, 63) != 0);
         tv = ($urandom_range(0, 9) < 4);
         rr = ($urandom_range(0, 1) == 1);
         td = 8'($urandom);
         bi = ($urandom_range(0, 3) != 0) ? m_word : 8'($urandom);
         step(r, tv, td, rr, bi);
         idle  = (t >= idle_from);
         e_txr = r && (idle || (t == word_end));
         e_gnt = r && idle && !tv;
         check("rnd_tx_ready",  t, 32'(tx_ready),  32'(e_txr));
         check("rnd_rx_gnt",    t, 32'(rx_gnt),    32'(e_gnt));
         check("rnd_bus_oe",    t, 32'(bus_oe),    32'(t <= word_end));
         check("rnd_bus_out",   t, 32'(bus_out),   32'(m_word));
         check("rnd_busy",      t, 32'(busy),      32'(!idle));
         check("rnd_rx_valid",  t, 32'(rx_valid),  32'(t == rd_time + 2));
         check("rnd_rx_data",   t, 32'(rx_data),   32'(m_rxd));
         check("rnd_collision", t, 32'(collision), 32'(m_coll));
         if (!r) begin
            word_end = -1000; idle_from = t + 1; rd_time = -1000;
            m_word = 8'h00; m_rxd = 8'h00; m_coll = 1'b0;
         end else begin
            if (COLL_EN && (t <= word_end) && (t != word_end - HOLD + 1) && (bi != m_word))
               m_coll = 1'b1;
            if (t == rd_time + 1) m_rxd = bi;
            if (tv && e_txr) begin
               word_end  = t + HOLD;
               idle_from = t + HOLD + TURN + 1;
               m_word    = td;
            end else if (rr && e_gnt) begin
               rd_time   = t;
               idle_from = t + 2;
            end
         end
         t++;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
